// File: rtl/axi4_lite_addr_map_package.sv
// axi4_lite_addr_map_package: address map, widths, response codes and write FSM states
package axi4_lite_addr_map_package;
    localparam int SLAVE_NUM   = 2;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int SLAVE_IDX_W = $clog2(SLAVE_NUM);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] SLAVE_BASE_ADDR [SLAVE_NUM] = '{32'h0000_0000, 32'h0000_0100};
    localparam logic [ADDR_WIDTH-1:0] SLAVE_ADDR_MASK [SLAVE_NUM] = '{32'hFFFF_FF00, 32'hFFFF_FF00};
    typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} wr_state_t;
endpackage

// File: rtl/axi4_lite_addr_decoder.sv
// axi4_lite_addr_decoder: combinational address to {hit, slave index} lookup
module axi4_lite_addr_decoder
    import axi4_lite_addr_map_package::*;
(
    input  logic [ADDR_WIDTH-1:0]  addr,
    output logic                   hit,
    output logic [SLAVE_IDX_W-1:0] idx
);
    // scan from the top down so the lowest matching index is the one left standing
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if ((addr & SLAVE_ADDR_MASK[i]) == (SLAVE_BASE_ADDR[i] & SLAVE_ADDR_MASK[i])) begin
                hit = 1'b1;
                idx = SLAVE_IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/axi4_lite_write_decoder.sv
// axi4_lite_write_decoder: routes one AXI4-Lite write at a time to the decoded slave, DECERR on miss
module axi4_lite_write_decoder
    import axi4_lite_addr_map_package::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [STRB_WIDTH-1:0]   s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    output logic [SLAVE_NUM-1:0]    m_awvalid,
    input  logic [SLAVE_NUM-1:0]    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [SLAVE_NUM-1:0]    m_wvalid,
    input  logic [SLAVE_NUM-1:0]    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [STRB_WIDTH-1:0]   m_wstrb,
    input  logic [SLAVE_NUM-1:0]    m_bvalid,
    output logic [SLAVE_NUM-1:0]    m_bready,
    input  logic [2*SLAVE_NUM-1:0]  m_bresp
);
    wr_state_t state, state_nxt;
    logic aw_held, w_held, aw_pend, w_pend;
    logic aw_fire, w_fire, both, aw_done, w_done, dec_hit;
    logic [SLAVE_IDX_W-1:0] sel, dec_idx;
    logic [ADDR_WIDTH-1:0] dec_addr;

    assign dec_addr = aw_held ? m_awaddr : s_awaddr;

    axi4_lite_addr_decoder u_dec (
        .addr (dec_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // next state and handshake outputs; everything held at 0 while in reset
    always_comb begin
        state_nxt = state;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RESP_OKAY;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        both      = 1'b0;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    s_awready = !aw_held;
                    s_wready  = !w_held;
                    aw_fire   = s_awvalid && !aw_held;
                    w_fire    = s_wvalid && !w_held;
                    both      = (aw_held || aw_fire) && (w_held || w_fire);
                    if (both) state_nxt = dec_hit ? FWD : ERR;
                end
                FWD: begin
                    m_awvalid[sel] = aw_pend;
                    m_wvalid[sel]  = w_pend;
                    aw_done = !aw_pend || m_awready[sel];
                    w_done  = !w_pend || m_wready[sel];
                    if (aw_done && w_done) state_nxt = RESP;
                end
                RESP: begin
                    s_bvalid      = m_bvalid[sel];
                    s_bresp       = m_bresp[2*sel +: 2];
                    m_bready[sel] = s_bready;
                    if (m_bvalid[sel] && s_bready) state_nxt = IDLE;
                end
                ERR: begin
                    s_bvalid = 1'b1;
                    s_bresp  = RESP_DECERR;
                    if (s_bready) state_nxt = IDLE;
                end
            endcase
        end
    end

    // capture AW/W once each, latch the decoded slave and track outstanding slave handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            sel      <= '0;
            m_awaddr <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
        end else begin
            if (aw_fire) m_awaddr <= s_awaddr;
            if (w_fire) begin
                m_wdata <= s_wdata;
                m_wstrb <= s_wstrb;
            end
            if (both) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                sel     <= dec_idx;
                aw_pend <= dec_hit;
                w_pend  <= dec_hit;
            end else begin
                if (aw_fire) aw_held <= 1'b1;
                if (w_fire) w_held <= 1'b1;
            end
            if (state == FWD) begin
                if (m_awready[sel]) aw_pend <= 1'b0;
                if (m_wready[sel]) w_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_write_decoder.sv
// tb_axi4_lite_write_decoder: directed checks of routing, DECERR, stalls, backpressure and reset
module tb_axi4_lite_write_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata, m_awaddr, m_wdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic [1:0]  s_bresp;
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [3:0]  m_bresp;
    int vectors = 0;
    int miscompares = 0;
    int aw_hs [2] = '{0, 0};
    int w_hs [2] = '{0, 0};
    int vcyc [2] = '{0, 0};
    int b_hs = 0;
    logic [31:0] last_addr [2];
    logic [31:0] last_data [2];

    axi4_lite_write_decoder dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    always #5 clk = ~clk;

    // slave-side and master-B handshake monitor
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (m_awvalid[i] && m_awready[i]) begin
                    aw_hs[i]++;
                    last_addr[i] = m_awaddr;
                end
                if (m_wvalid[i] && m_wready[i]) begin
                    w_hs[i]++;
                    last_data[i] = m_wdata;
                end
                if (m_awvalid[i] || m_wvalid[i]) vcyc[i]++;
            end
            if (s_bvalid && s_bready) b_hs++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d);
        s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d; s_wstrb = 4'hF;
        #1;
        vectors++; if ({s_awready, s_wready} !== 2'b11) begin miscompares++; $display("FAIL accept %h: ready got %b expected 11", a, {s_awready, s_wready}); end
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        step(); step();
        vectors++; if ({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready} !== 9'b0) begin miscompares++; $display("FAIL reset_outputs: got %b expected 0", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}); end
        rst = 1'b0;
        #1;
        vectors++; if ({s_awready, s_wready} !== 2'b11) begin miscompares++; $display("FAIL reset_idle_ready: got %b expected 11", {s_awready, s_wready}); end
        vectors++; if ({m_awaddr, m_wdata, m_wstrb} !== 68'b0) begin miscompares++; $display("FAIL reset_regs: got %h expected 0", {m_awaddr, m_wdata, m_wstrb}); end
    endtask

    task automatic test_slave0_write();
        int a0 = aw_hs[0], w0 = w_hs[0], v1 = vcyc[1], b0 = b_hs;
        m_awready = 2'b11; m_wready = 2'b11;
        issue(32'h0000_0040, 32'hDEAD_BEEF);
        vectors++; if ({m_awvalid, m_wvalid} !== 4'b0101) begin miscompares++; $display("FAIL s0_fwd_valid: got %b expected 0101", {m_awvalid, m_wvalid}); end
        vectors++; if (m_awaddr !== 32'h40 || m_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL s0_fwd_payload: got %h/%h expected 00000040/deadbeef", m_awaddr, m_wdata); end
        step();
        vectors++; if ({m_awvalid, m_wvalid, s_bvalid} !== 5'b0) begin miscompares++; $display("FAIL s0_resp_wait: got %b expected 0", {m_awvalid, m_wvalid, s_bvalid}); end
        m_bvalid = 2'b01; m_bresp = 4'b0000; s_bready = 1'b1;
        #1;
        vectors++; if ({s_bvalid, s_bresp, m_bready} !== 5'b1_00_01) begin miscompares++; $display("FAIL s0_bresp: got %b expected 10001", {s_bvalid, s_bresp, m_bready}); end
        step();
        m_bvalid = 0; s_bready = 0;
        vectors++; if (aw_hs[0] - a0 !== 1 || w_hs[0] - w0 !== 1) begin miscompares++; $display("FAIL s0_once: got aw %0d w %0d expected 1 1", aw_hs[0] - a0, w_hs[0] - w0); end
        vectors++; if (last_addr[0] !== 32'h40 || last_data[0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL s0_seen: got %h/%h expected 00000040/deadbeef", last_addr[0], last_data[0]); end
        vectors++; if (vcyc[1] - v1 !== 0) begin miscompares++; $display("FAIL s0_s1_idle: got %0d expected 0", vcyc[1] - v1); end
        vectors++; if (b_hs - b0 !== 1) begin miscompares++; $display("FAIL s0_b_count: got %0d expected 1", b_hs - b0); end
    endtask

    task automatic test_slave1_slverr();
        int a1 = aw_hs[1], v0 = vcyc[0];
        issue(32'h0000_0180, 32'h1234_5678);
        vectors++; if ({m_awvalid, m_wvalid} !== 4'b1010) begin miscompares++; $display("FAIL s1_fwd_valid: got %b expected 1010", {m_awvalid, m_wvalid}); end
        step();
        m_bvalid = 2'b10; m_bresp = 4'b1000; s_bready = 1'b1;
        #1;
        vectors++; if ({s_bvalid, s_bresp, m_bready} !== 5'b1_10_10) begin miscompares++; $display("FAIL s1_slverr: got %b expected 11010", {s_bvalid, s_bresp, m_bready}); end
        step();
        m_bvalid = 0; m_bresp = 0; s_bready = 0;
        vectors++; if (aw_hs[1] - a1 !== 1 || last_addr[1] !== 32'h180 || last_data[1] !== 32'h1234_5678) begin miscompares++; $display("FAIL s1_seen: got %0d %h %h expected 1 00000180 12345678", aw_hs[1] - a1, last_addr[1], last_data[1]); end
        vectors++; if (vcyc[0] - v0 !== 0) begin miscompares++; $display("FAIL s1_s0_idle: got %0d expected 0", vcyc[0] - v0); end
    endtask

    task automatic test_decerr();
        int v0 = vcyc[0], v1 = vcyc[1];
        issue(32'h0001_0000, 32'h5555_AAAA);
        vectors++; if ({s_bvalid, s_bresp} !== 3'b111) begin miscompares++; $display("FAIL decerr_b: got %b expected 111", {s_bvalid, s_bresp}); end
        vectors++; if ({m_awvalid, m_wvalid} !== 4'b0) begin miscompares++; $display("FAIL decerr_no_fwd: got %b expected 0000", {m_awvalid, m_wvalid}); end
        s_bready = 1'b1;
        #1;
        vectors++; if (m_bready !== 2'b00) begin miscompares++; $display("FAIL decerr_bready: got %b expected 00", m_bready); end
        step();
        s_bready = 0;
        vectors++; if ({s_bvalid, s_awready} !== 2'b01) begin miscompares++; $display("FAIL decerr_back_idle: got %b expected 01", {s_bvalid, s_awready}); end
        vectors++; if (vcyc[0] - v0 !== 0 || vcyc[1] - v1 !== 0) begin miscompares++; $display("FAIL decerr_slaves_quiet: got %0d %0d expected 0 0", vcyc[0] - v0, vcyc[1] - v1); end
    endtask

    task automatic test_w_first_aw_stall();
        int a0 = aw_hs[0], w0 = w_hs[0];
        m_awready = 2'b00; m_wready = 2'b11;
        s_wvalid = 1'b1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'h3;
        #1;
        vectors++; if (s_wready !== 1'b1) begin miscompares++; $display("FAIL wfirst_accept: got %b expected 1", s_wready); end
        step();
        s_wdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 3; k++) begin
            vectors++; if ({s_wready, s_awready} !== 2'b01) begin miscompares++; $display("FAIL wfirst_held_%0d: got %b expected 01", k, {s_wready, s_awready}); end
            if (k == 2) begin s_awvalid = 1'b1; s_awaddr = 32'h0000_0044; end
            step();
        end
        s_awvalid = 0; s_wvalid = 0;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (m_awvalid !== 2'b01 || m_wdata !== 32'hCAFE_F00D || m_wstrb !== 4'h3) begin miscompares++; $display("FAIL awstall_%0d: got %b %h %h expected 01 cafef00d 3", k, m_awvalid, m_wdata, m_wstrb); end
            vectors++; if (m_wvalid !== (k == 0 ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL awstall_w_%0d: got %b expected %b", k, m_wvalid, (k == 0 ? 2'b01 : 2'b00)); end
            step();
        end
        m_awready = 2'b11;
        step();
        vectors++; if (aw_hs[0] - a0 !== 1 || w_hs[0] - w0 !== 1 || last_addr[0] !== 32'h44) begin miscompares++; $display("FAIL awstall_single: got %0d %0d %h expected 1 1 00000044", aw_hs[0] - a0, w_hs[0] - w0, last_addr[0]); end
        m_bvalid = 2'b01; s_bready = 1'b1;
        step();
        m_bvalid = 0; s_bready = 0;
    endtask

    task automatic test_bready_backpressure();
        int b0 = b_hs;
        issue(32'h0000_0040, 32'h0000_0001);
        step();
        m_bvalid = 2'b01; m_bresp = 4'b0000; s_bready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++; if ({s_bvalid, s_awready, s_wready, m_bready} !== 5'b10000) begin miscompares++; $display("FAIL bp_hold_%0d: got %b expected 10000", k, {s_bvalid, s_awready, s_wready, m_bready}); end
            step();
        end
        s_bready = 1'b1;
        #1;
        vectors++; if (m_bready !== 2'b01) begin miscompares++; $display("FAIL bp_bready: got %b expected 01", m_bready); end
        step();
        m_bvalid = 0; s_bready = 0;
        vectors++; if ({s_awready, s_wready, s_bvalid} !== 3'b110) begin miscompares++; $display("FAIL bp_b2b_ready: got %b expected 110", {s_awready, s_wready, s_bvalid}); end
        vectors++; if (b_hs - b0 !== 1) begin miscompares++; $display("FAIL bp_b_count: got %0d expected 1", b_hs - b0); end
    endtask

    task automatic test_reset_mid_fwd();
        int b0 = b_hs, a0;
        m_awready = 2'b00; m_wready = 2'b00;
        issue(32'h0000_0040, 32'h7777_7777);
        vectors++; if ({m_awvalid, m_wvalid} !== 4'b0101) begin miscompares++; $display("FAIL rstfwd_pre: got %b expected 0101", {m_awvalid, m_wvalid}); end
        rst = 1'b1;
        #1;
        vectors++; if ({m_awvalid, m_wvalid, s_awready, s_wready} !== 6'b0) begin miscompares++; $display("FAIL rstfwd_during: got %b expected 0", {m_awvalid, m_wvalid, s_awready, s_wready}); end
        step();
        rst = 1'b0;
        m_awready = 2'b11; m_wready = 2'b11;
        #1;
        vectors++; if ({m_awvalid, m_wvalid, s_bvalid, m_awaddr} !== 37'b0) begin miscompares++; $display("FAIL rstfwd_after: got %h expected 0", {m_awvalid, m_wvalid, s_bvalid, m_awaddr}); end
        step(); step();
        vectors++; if (b_hs - b0 !== 0 || s_bvalid !== 1'b0) begin miscompares++; $display("FAIL rstfwd_no_b: got %0d %b expected 0 0", b_hs - b0, s_bvalid); end
        a0 = aw_hs[0];
        issue(32'h0000_0040, 32'h8888_8888);
        step();
        m_bvalid = 2'b01; m_bresp = 4'b0000; s_bready = 1'b1;
        #1;
        vectors++; if ({s_bvalid, s_bresp} !== 3'b100) begin miscompares++; $display("FAIL rstfwd_redo_okay: got %b expected 100", {s_bvalid, s_bresp}); end
        step();
        m_bvalid = 0; s_bready = 0;
        vectors++; if (aw_hs[0] - a0 !== 1 || last_data[0] !== 32'h8888_8888) begin miscompares++; $display("FAIL rstfwd_redo_fwd: got %0d %h expected 1 88888888", aw_hs[0] - a0, last_data[0]); end
    endtask

    initial begin
        test_reset();
        test_slave0_write();
        test_slave1_slverr();
        test_decerr();
        test_w_first_aw_stall();
        test_bready_backpressure();
        test_reset_mid_fwd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
